lane_merge_4to1: RTL and testbench
==================================

# lane_merge_4to1

Four-lane to single-lane merge stage that sits directly downstream of the recirculation demux. It consumes the four 8-bit data/valid lanes the recirculation block forwards, buffers each lane in a small FIFO, and drains them round-robin onto one byte-wide output, one byte per clock. It also reports per-lane full and overflow status and an idle indication for the serializer further down.

## Interface
Parameters:
- DW, 8, data width of every lane.
- DEPTH, 4, entries per lane FIFO; power of two, minimum 2.

Ports:
- clk_4f  in  1  sole clock; every register updates on its rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- data_0, data_1, data_2, data_3  in  DW each  lane input bytes.
- valid_0, valid_1, valid_2, valid_3  in  1 each  lane byte present this cycle.
- data_out  out  DW  merged output byte, registered.
- valid_out  out  1  data_out carries a real byte, registered.
- full_0..full_3  out  1 each  lane FIFO holds DEPTH entries; combinational from the registered count.
- overflow_0..overflow_3  out  1 each  sticky flag: a byte was dropped on this lane.
- idle_out  out  1  registered; high when the block is in the IDLE state.

## Operation
- Lane FIFO: circular buffer with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- Push: valid_k=1 and count_k<DEPTH writes data_k at the write pointer.
- Push when count_k==DEPTH: the byte is dropped and overflow_k is set. This holds even if lane k is popped in the same cycle.
- overflow_k clears only on reset.
- Arbiter: a 2-bit rr_ptr; the candidate lane is the first lane with count>0, searching rr_ptr, rr_ptr+1, … mod 4.
- When a candidate exists, that lane is popped and rr_ptr is set to granted+1 (mod 4).
- When no candidate exists, rr_ptr holds.
- Emptiness is judged on the registered count, so a byte pushed at edge n is not eligible until the cycle after edge n.
- Simultaneous push and pop on the same lane: both occur, and count is unchanged.
- State machine:
  - IDLE: idle_out=1. Moves to ACTIVE when any push is accepted.
  - ACTIVE: idle_out=0. Moves to DRAIN when all counts are 0 and no push is accepted this cycle.
  - DRAIN: idle_out=0; the last byte is on the output. Moves to IDLE next cycle unless a push is accepted, in which case it moves to ACTIVE.
- Reset asserted mid-operation: all buffered bytes are discarded. After release the block starts in IDLE with rr_ptr=0.

## Timing
- Reset values: data_out=0, valid_out=0, idle_out=1, full_k=0, overflow_k=0, all counts/pointers/rr_ptr=0, state IDLE.
- Latency: a byte captured at edge n into an empty FIFO is popped and registered onto data_out at edge n+1, so it is visible during the cycle after edge n+1.
- Throughput: one output byte per clock while any FIFO is non-empty. The output has no gaps while data is buffered.
- valid_out=0 in every cycle with no pop at the preceding edge.
- No backpressure input: downstream must accept every byte.
- Upstream must respect full_k; otherwise bytes are dropped as specified above.

## Configuration
- IDLE_BYTE_EN defined: data_out is driven with 8'hBC (K28.5 idle symbol) in every cycle where valid_out=0, including out of reset. Only the low 8 bits are driven if DW>8; the rest are 0.
- IDLE_BYTE_EN undefined: data_out holds its last value when valid_out=0, and is 0 after reset.

## Test plan
- Reset sequence: hold reset=0 for 20 cycles, then release.
  - During reset: all outputs at reset values and idle_out=1.
  - Driving valids while reset=0 produces no output.
- Single beat: release reset, drive data 0xFF/0xEE/0xDD/0xCC on lanes 0–3 with all valids for one cycle.
  - Output: data_out = FF, EE, DD, CC on four consecutive cycles, the first one cycle after capture.
  - idle_out then goes low → DRAIN → high.
- Round-robin fairness: keep lanes 1 and 3 fed every cycle with incrementing bytes.
  - Output alternates lane 1 / lane 3 strictly.
  - Lanes 0 and 2 never appear; full_1 and full_3 eventually assert.
- Overflow: push 5 bytes on lane 2 only while lanes 0, 1 and 3 are kept nonempty.
  - Once lane 2 holds 4 entries, full_2=1 and the next push on lane 2 (e.g. 0x77) is dropped.
  - overflow_2=1 and stays 1; the other overflow flags stay 0.
- Mid-operation reset: assert reset with bytes queued in all lanes.
  - Outputs return to reset values asynchronously, before the next edge.
  - After release, no stale byte appears; the first new byte appears with the normal latency.
- Idle byte: with IDLE_BYTE_EN defined, data_out=0xBC whenever valid_out=0. Without it, data_out holds the last byte.

Source files
------------

// File: rtl/lane_merge_4to1.sv
// lane_merge_4to1: four byte lanes, each buffered in a small FIFO, merged
// round-robin onto one registered output at one byte per clock.
// Optional feature macro: IDLE_BYTE_EN (drive 8'hBC on data_out while idle).
module lane_merge_4to1 #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk_4f,
    input  logic          reset,
    input  logic [DW-1:0] data_0,
    input  logic [DW-1:0] data_1,
    input  logic [DW-1:0] data_2,
    input  logic [DW-1:0] data_3,
    input  logic          valid_0,
    input  logic          valid_1,
    input  logic          valid_2,
    input  logic          valid_3,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    output logic          full_0,
    output logic          full_1,
    output logic          full_2,
    output logic          full_3,
    output logic          overflow_0,
    output logic          overflow_1,
    output logic          overflow_2,
    output logic          overflow_3,
    output logic          idle_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
`ifdef IDLE_BYTE_EN
    localparam logic [DW-1:0] IDLE_DATA = DW'(8'hBC);
`else
    localparam logic [DW-1:0] IDLE_DATA = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    logic [DW-1:0] r_mem [4][DEPTH];
    logic [AW-1:0] r_wptr [4];
    logic [AW-1:0] r_rptr [4];
    logic [CW-1:0] r_count [4];
    logic [3:0]    r_ovf;
    logic [1:0]    r_rr;
    logic [DW-1:0] r_data_out;
    logic          r_valid_out;
    logic          r_idle;
    state_t        r_state;

    logic [DW-1:0] w_data [4];
    logic [3:0]    w_valid;
    logic [3:0]    w_full;
    logic [3:0]    w_push;
    logic [3:0]    w_pop;
    logic          w_any_push;
    logic          w_all_empty;
    logic          w_grant_vld;
    logic [1:0]    w_grant;

    assign w_data[0] = data_0;
    assign w_data[1] = data_1;
    assign w_data[2] = data_2;
    assign w_data[3] = data_3;
    assign w_valid   = {valid_3, valid_2, valid_1, valid_0};

    // Per-lane full flags and accepted pushes (a push into a full lane is dropped).
    always_comb begin
        w_full      = '0;
        w_push      = '0;
        w_all_empty = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w_full[k] = (r_count[k] == CW'(DEPTH));
            w_push[k] = w_valid[k] && !w_full[k];
            if (r_count[k] != '0) begin
                w_all_empty = 1'b0;
            end
        end
        w_any_push = |w_push;
    end

    // Round-robin search from r_rr; descending loop so the nearest lane wins.
    always_comb begin
        logic [1:0] v_idx;
        v_idx       = r_rr;
        w_grant_vld = 1'b0;
        w_grant     = r_rr;
        w_pop       = '0;
        for (int i = 3; i >= 0; i--) begin
            v_idx = r_rr + 2'(i);
            if (r_count[v_idx] != '0) begin
                w_grant_vld = 1'b1;
                w_grant     = v_idx;
            end
        end
        for (int k = 0; k < 4; k++) begin
            w_pop[k] = w_grant_vld && (w_grant == 2'(k));
        end
    end

    // Lane storage; contents need no reset since counts gate every read.
    always_ff @(posedge clk_4f) begin
        for (int k = 0; k < 4; k++) begin
            if (w_push[k]) begin
                r_mem[k][r_wptr[k]] <= w_data[k];
            end
        end
    end

    // FIFO pointers, counts and sticky overflow flags.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                r_wptr[k]  <= '0;
                r_rptr[k]  <= '0;
                r_count[k] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_push[k]) begin
                    r_wptr[k] <= r_wptr[k] + AW'(1);
                end
                if (w_pop[k]) begin
                    r_rptr[k] <= r_rptr[k] + AW'(1);
                end
                r_count[k] <= r_count[k] + CW'(w_push[k]) - CW'(w_pop[k]);
                if (w_valid[k] && w_full[k]) begin
                    r_ovf[k] <= 1'b1;
                end
            end
        end
    end

    // Output register and arbiter pointer.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_data_out  <= IDLE_DATA;
            r_valid_out <= 1'b0;
            r_rr        <= '0;
        end else if (w_grant_vld) begin
            r_data_out  <= r_mem[w_grant][r_rptr[w_grant]];
            r_valid_out <= 1'b1;
            r_rr        <= w_grant + 2'd1;
        end else begin
            r_valid_out <= 1'b0;
`ifdef IDLE_BYTE_EN
            r_data_out  <= IDLE_DATA;
`endif
        end
    end

    // Activity FSM; idle flag is registered alongside the state.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idle  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_push) begin
                        r_state <= ST_ACTIVE;
                        r_idle  <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_all_empty && !w_any_push) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_any_push) begin
                        r_state <= ST_ACTIVE;
                    end else begin
                        r_state <= ST_IDLE;
                        r_idle  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign idle_out   = r_idle;
    assign full_0     = w_full[0];
    assign full_1     = w_full[1];
    assign full_2     = w_full[2];
    assign full_3     = w_full[3];
    assign overflow_0 = r_ovf[0];
    assign overflow_1 = r_ovf[1];
    assign overflow_2 = r_ovf[2];
    assign overflow_3 = r_ovf[3];

endmodule

// File: tb/tb_lane_merge_4to1.sv
// Bench for lane_merge_4to1: queue-based reference model, randomized traffic.
module tb_lane_merge_4to1;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
`ifdef IDLE_BYTE_EN
    localparam logic [7:0] RST_D = 8'hBC;
`else
    localparam logic [7:0] RST_D = 8'h00;
`endif

    logic          clk_4f = 1'b0;
    logic          reset  = 1'b0;
    logic [DW-1:0] data_0 = '0, data_1 = '0, data_2 = '0, data_3 = '0;
    logic          valid_0 = 1'b0, valid_1 = 1'b0, valid_2 = 1'b0, valid_3 = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full_0, full_1, full_2, full_3;
    logic          overflow_0, overflow_1, overflow_2, overflow_3;
    logic          idle_out;
    logic [3:0]    dut_full, dut_ovf;

    assign dut_full = {full_3, full_2, full_1, full_0};
    assign dut_ovf  = {overflow_3, overflow_2, overflow_1, overflow_0};

    always #5 clk_4f = ~clk_4f;

    lane_merge_4to1 #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk_4f(clk_4f), .reset(reset),
        .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
        .data_out(data_out), .valid_out(valid_out),
        .full_0(full_0), .full_1(full_1), .full_2(full_2), .full_3(full_3),
        .overflow_0(overflow_0), .overflow_1(overflow_1),
        .overflow_2(overflow_2), .overflow_3(overflow_3),
        .idle_out(idle_out)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per lane plus arbiter pointer and flags.
    logic [7:0] q [4][$];
    int         m_rr;
    logic [3:0] m_ovf;
    int         m_quiet;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic [7:0] drv_d [4];
    logic       drv_v [4];

    function automatic logic [3:0] m_full_vec();
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (q[k].size() == DEPTH);
        return r;
    endfunction

    // 1: must be idle, 0: must be busy, -1: transitional, not checked.
    function automatic int m_idle();
        int busy;
        busy = exp_valid ? 1 : 0;
        for (int k = 0; k < 4; k++) if (q[k].size() > 0) busy = 1;
        if (m_quiet >= 2) return 1;
        if (busy != 0) return 0;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            drv_v[k] = 1'b0;
            drv_d[k] = 8'h00;
        end
        m_rr      = 0;
        m_ovf     = '0;
        m_quiet   = 2;
        exp_valid = 1'b0;
        exp_data  = RST_D;
    endtask

    // Apply the driver arrays for one clock and advance the model accordingly.
    task automatic step();
        int   g;
        logic acc [4];
        logic any_acc;
        logic all_empty;
        data_0 = drv_d[0]; data_1 = drv_d[1]; data_2 = drv_d[2]; data_3 = drv_d[3];
        valid_0 = drv_v[0]; valid_1 = drv_v[1]; valid_2 = drv_v[2]; valid_3 = drv_v[3];
        g = -1;
        for (int i = 0; i < 4; i++) begin
            if (g < 0 && q[(m_rr + i) % 4].size() > 0) g = (m_rr + i) % 4;
        end
        any_acc   = 1'b0;
        all_empty = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (q[k].size() > 0) all_empty = 1'b0;
            acc[k] = drv_v[k] && (q[k].size() < DEPTH);
            if (drv_v[k] && !acc[k]) m_ovf[k] = 1'b1;
            if (acc[k]) any_acc = 1'b1;
        end
        if (!any_acc && all_empty) m_quiet++;
        else m_quiet = 0;
        if (g >= 0) begin
            exp_data  = q[g].pop_front();
            exp_valid = 1'b1;
            m_rr      = (g + 1) % 4;
        end else begin
            exp_valid = 1'b0;
`ifdef IDLE_BYTE_EN
            exp_data  = 8'hBC;
`endif
        end
        for (int k = 0; k < 4; k++) if (acc[k]) q[k].push_back(drv_d[k]);
        @(posedge clk_4f);
        #1;
        for (int k = 0; k < 4; k++) drv_v[k] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_4f);
        reset = 1'b0;
        repeat (2) @(negedge clk_4f);
        model_reset();
        valid_0 = 1'b0; valid_1 = 1'b0; valid_2 = 1'b0; valid_3 = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 20; c++) begin
            valid_0 = 1'($urandom); valid_1 = 1'($urandom);
            valid_2 = 1'($urandom); valid_3 = 1'($urandom);
            data_0 = 8'($urandom); data_1 = 8'($urandom);
            data_2 = 8'($urandom); data_3 = 8'($urandom);
            @(negedge clk_4f);
            checks++;
            if (valid_out !== 1'b0 || data_out !== RST_D || idle_out !== 1'b1 ||
                dut_full !== 4'b0 || dut_ovf !== 4'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d valid=%b data=%h idle=%b full=%b ovf=%b required 0/%h/1/0000/0000",
                         c, valid_out, data_out, idle_out, dut_full, dut_ovf, RST_D);
            end
        end
        valid_0 = 1'b0; valid_1 = 1'b0; valid_2 = 1'b0; valid_3 = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_single_beat();
        logic [7:0] seq [4];
        seq = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
        for (int k = 0; k < 4; k++) begin
            drv_d[k] = seq[k];
            drv_v[k] = 1'b1;
        end
        step();
        checks++;
        if (valid_out !== 1'b0 || idle_out !== 1'b0) begin
            failures++;
            $display("FAIL beat_capture valid=%b idle=%b required 0/0", valid_out, idle_out);
        end
        for (int j = 0; j < 4; j++) begin
            step();
            checks++;
            if (valid_out !== 1'b1 || data_out !== seq[j]) begin
                failures++;
                $display("FAIL beat_seq idx=%0d valid=%b data=%h required 1/%h", j, valid_out, data_out, seq[j]);
            end
        end
        for (int j = 0; j < 6; j++) begin
            step();
            checks++;
`ifdef IDLE_BYTE_EN
            if (valid_out !== 1'b0 || data_out !== 8'hBC) begin
`else
            if (valid_out !== 1'b0 || data_out !== 8'hCC) begin
`endif
                failures++;
                $display("FAIL beat_after idx=%0d valid=%b data=%h", j, valid_out, data_out);
            end
            if (m_idle() >= 0) begin
                checks++;
                if (idle_out !== 1'(m_idle())) begin
                    failures++;
                    $display("FAIL beat_idle idx=%0d idle=%b required %0d", j, idle_out, m_idle());
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int last_src;
        int src;
        logic saw_f1, saw_f3;
        last_src = -1;
        saw_f1 = 1'b0;
        saw_f3 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i < 40) begin
                drv_v[1] = 1'b1; drv_d[1] = 8'(i) & 8'h7F;
                drv_v[3] = 1'b1; drv_d[3] = 8'h80 | 8'(i);
            end
            step();
            checks++;
            if (valid_out !== exp_valid || data_out !== exp_data) begin
                failures++;
                $display("FAIL rr_out i=%0d valid=%b data=%h required %b/%h", i, valid_out, data_out, exp_valid, exp_data);
            end
            if (valid_out === 1'b1) begin
                src = data_out[7] ? 3 : 1;
                if (last_src >= 0 && i < 40) begin
                    checks++;
                    if (src == last_src) begin
                        failures++;
                        $display("FAIL rr_alternate i=%0d lane=%0d repeated", i, src);
                    end
                end
                last_src = src;
            end
            if (full_1 === 1'b1) saw_f1 = 1'b1;
            if (full_3 === 1'b1) saw_f3 = 1'b1;
            checks++;
            if (dut_full !== m_full_vec() || dut_ovf !== m_ovf) begin
                failures++;
                $display("FAIL rr_flags i=%0d full=%b ovf=%b required %b/%b", i, dut_full, dut_ovf, m_full_vec(), m_ovf);
            end
        end
        checks++;
        if (!(saw_f1 && saw_f3)) begin
            failures++;
            $display("FAIL rr_full_seen full_1=%b full_3=%b required 1/1", saw_f1, saw_f3);
        end
    endtask

    task automatic test_overflow();
        int   n;
        logic sent77;
        logic saw77;
        do_reset();
        n = 0;
        sent77 = 1'b0;
        saw77  = 1'b0;
        for (int i = 0; i < 30 && !sent77; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (k != 2) begin
                    drv_v[k] = (q[k].size() < DEPTH);
                    drv_d[k] = 8'($urandom) & 8'h3F;
                end
            end
            drv_v[2] = 1'b1;
            if (q[2].size() < DEPTH) begin
                drv_d[2] = 8'h40 + 8'(n);
                n++;
            end else begin
                checks++;
                if (full_2 !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_full2 full_2=%b required 1", full_2);
                end
                drv_d[2] = 8'h77;
                sent77 = 1'b1;
            end
            step();
            if (valid_out === 1'b1 && data_out === 8'h77) saw77 = 1'b1;
        end
        checks++;
        if (!sent77 || dut_ovf !== 4'b0100) begin
            failures++;
            $display("FAIL ovf_set reached_full=%b ovf=%b required 1/0100", sent77, dut_ovf);
        end
        for (int i = 0; i < 25; i++) begin
            if (i < 10) begin
                for (int k = 0; k < 4; k++) begin
                    if (k != 2) begin
                        drv_v[k] = (q[k].size() < DEPTH);
                        drv_d[k] = 8'($urandom) & 8'h3F;
                    end
                end
            end
            step();
            if (valid_out === 1'b1 && data_out === 8'h77) saw77 = 1'b1;
            checks++;
            if (valid_out !== exp_valid || data_out !== exp_data || dut_ovf !== 4'b0100 ||
                dut_full !== m_full_vec()) begin
                failures++;
                $display("FAIL ovf_drain i=%0d valid=%b data=%h ovf=%b full=%b required %b/%h/0100/%b",
                         i, valid_out, data_out, dut_ovf, dut_full, exp_valid, exp_data, m_full_vec());
            end
        end
        checks++;
        if (saw77) begin
            failures++;
            $display("FAIL ovf_dropped byte 77 appeared=%b required 0", saw77);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                drv_v[k] = 1'b1;
                drv_d[k] = 8'($urandom);
            end
            step();
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== RST_D || idle_out !== 1'b1 ||
            dut_full !== 4'b0 || dut_ovf !== 4'b0) begin
            failures++;
            $display("FAIL midrst_async valid=%b data=%h idle=%b full=%b ovf=%b required 0/%h/1/0000/0000",
                     valid_out, data_out, idle_out, dut_full, dut_ovf, RST_D);
        end
        valid_0 = 1'b0; valid_1 = 1'b0; valid_2 = 1'b0; valid_3 = 1'b0;
        repeat (3) @(negedge clk_4f);
        model_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (valid_out !== 1'b0 || data_out !== RST_D || idle_out !== 1'b1) begin
                failures++;
                $display("FAIL midrst_stale i=%0d valid=%b data=%h idle=%b required 0/%h/1", i, valid_out, data_out, idle_out, RST_D);
            end
        end
        drv_v[2] = 1'b1;
        drv_d[2] = 8'h5A;
        step();
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL midrst_lat0 valid=%b required 0", valid_out);
        end
        step();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 8'h5A) begin
            failures++;
            $display("FAIL midrst_lat1 valid=%b data=%h required 1/5a", valid_out, data_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i < 360) begin
                for (int k = 0; k < 4; k++) begin
                    drv_v[k] = ($urandom_range(0, 99) < 40) &&
                               ((q[k].size() < DEPTH) || ($urandom_range(0, 9) == 0));
                    drv_d[k] = 8'($urandom);
                end
            end
            step();
            checks++;
            if (valid_out !== exp_valid || data_out !== exp_data ||
                dut_full !== m_full_vec() || dut_ovf !== m_ovf) begin
                failures++;
                $display("FAIL rand i=%0d valid=%b data=%h full=%b ovf=%b required %b/%h/%b/%b",
                         i, valid_out, data_out, dut_full, dut_ovf, exp_valid, exp_data, m_full_vec(), m_ovf);
            end
            if (m_idle() >= 0) begin
                checks++;
                if (idle_out !== 1'(m_idle())) begin
                    failures++;
                    $display("FAIL rand_idle i=%0d idle=%b required %0d", i, idle_out, m_idle());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_round_robin();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
